// File: rtl/tor_fanin_switch.sv
// tor_fanin_switch: buffered N-port loopback ToR switch.
// Every source has its own ingress FIFO. Each destination has a round-robin
// arbiter that serialises fan-in traffic, so simultaneous packets to one
// destination are delivered in turn instead of overwriting each other.
// A packet is dropped only on ingress overflow or an out-of-range destination,
// and each drop is counted per source with saturating counters.
module tor_fanin_switch #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned DEST_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          tx_valid,
  input  logic [N_PORTS*DATA_W-1:0]   tx_data,
  input  logic [N_PORTS*DEST_W-1:0]   tx_dest,
  output logic [N_PORTS-1:0]          rx_valid,
  output logic [N_PORTS*DATA_W-1:0]   rx_data,
  output logic [N_PORTS*DEST_W-1:0]   rx_src,
  output logic [N_PORTS*CNT_W-1:0]    ovf_drop_cnt,
  output logic [N_PORTS*CNT_W-1:0]    bad_dest_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One buffered packet: destination travels with the payload.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Ingress FIFO storage and pointers (extra MSB distinguishes full/empty).
  entry_t            mem_q  [N_PORTS][FIFO_DEPTH];
  logic [PW-1:0]     wptr_q [N_PORTS];
  logic [PW-1:0]     rptr_q [N_PORTS];

  // Round-robin pointers, one per destination.
  logic [SW-1:0]     rr_q   [N_PORTS];
  logic [SW-1:0]     rr_d   [N_PORTS];

  // Drop counters.
  logic [CNT_W-1:0]  ovf_q  [N_PORTS];
  logic [CNT_W-1:0]  bad_q  [N_PORTS];

  // Registered egress.
  logic [N_PORTS-1:0] rx_valid_q;
  logic [DATA_W-1:0]  rx_data_q [N_PORTS];
  logic [DEST_W-1:0]  rx_src_q  [N_PORTS];

  // Combinational status / control.
  logic [N_PORTS-1:0] empty_c;
  logic [N_PORTS-1:0] full_c;
  entry_t             head_c    [N_PORTS];
  logic [DEST_W-1:0]  dest_c    [N_PORTS];
  logic [N_PORTS-1:0] bad_c;
  logic [N_PORTS-1:0] ovf_c;
  logic [N_PORTS-1:0] push_c;
  logic [N_PORTS-1:0] pop_c;
  logic [N_PORTS-1:0] gnt_vld_c;
  logic [SW-1:0]      gnt_src_c [N_PORTS];

  // FIFO occupancy flags and head entry per source.
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int s = 0; s < int'(N_PORTS); s++) begin
      empty_c[s] = (wptr_q[s] == rptr_q[s]);
      full_c[s]  = (wptr_q[s][AW] != rptr_q[s][AW]) &&
                   (wptr_q[s][AW-1:0] == rptr_q[s][AW-1:0]);
      head_c[s]  = mem_q[s][rptr_q[s][AW-1:0]];
    end
  end

  // Per-destination round-robin search starting at rr_q, plus FIFO pops.
  always_comb begin
    gnt_vld_c = '0;
    pop_c     = '0;
    for (int d = 0; d < int'(N_PORTS); d++) begin
      gnt_src_c[d] = '0;
      rr_d[d]      = rr_q[d];
    end
    for (int d = 0; d < int'(N_PORTS); d++) begin
      for (int unsigned off = 0; off < N_PORTS; off++) begin
        int unsigned   sum;
        logic [SW-1:0] idx;
        sum = 32'(rr_q[d]) + off;
        if (sum >= N_PORTS) begin
          sum = sum - N_PORTS;
        end
        idx = SW'(sum);
        if (!gnt_vld_c[d] && !empty_c[idx] && (head_c[idx].dest == DEST_W'(d))) begin
          gnt_vld_c[d] = 1'b1;
          gnt_src_c[d] = idx;
        end
      end
      if (gnt_vld_c[d]) begin
        pop_c[gnt_src_c[d]] = 1'b1;
        if (gnt_src_c[d] == SW'(N_PORTS - 1)) begin
          rr_d[d] = '0;
        end else begin
          rr_d[d] = gnt_src_c[d] + SW'(1);
        end
      end
    end
  end

  // Ingress classification: bad destination, overflow drop, or push.
  always_comb begin
    bad_c  = '0;
    ovf_c  = '0;
    push_c = '0;
    for (int s = 0; s < int'(N_PORTS); s++) begin
      dest_c[s] = tx_dest[s*DEST_W +: DEST_W];
      if (tx_valid[s]) begin
        if (dest_c[s] >= DEST_W'(N_PORTS)) begin
          bad_c[s] = 1'b1;
        end else if (full_c[s] && !pop_c[s]) begin
          ovf_c[s] = 1'b1;
        end else begin
          push_c[s] = 1'b1;
        end
      end
    end
  end

  // FIFO pointers, RR pointers and saturating drop counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < int'(N_PORTS); s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        rr_q[s]   <= '0;
        ovf_q[s]  <= '0;
        bad_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < int'(N_PORTS); s++) begin
        rr_q[s] <= rr_d[s];
        if (push_c[s]) begin
          wptr_q[s] <= wptr_q[s] + PW'(1);
        end
        if (pop_c[s]) begin
          rptr_q[s] <= rptr_q[s] + PW'(1);
        end
        if (ovf_c[s] && (ovf_q[s] != CNT_MAX)) begin
          ovf_q[s] <= ovf_q[s] + CNT_W'(1);
        end
        if (bad_c[s] && (bad_q[s] != CNT_MAX)) begin
          bad_q[s] <= bad_q[s] + CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    for (int s = 0; s < int'(N_PORTS); s++) begin
      if (reset && push_c[s]) begin
        mem_q[s][wptr_q[s][AW-1:0]] <= '{dest: dest_c[s], data: tx_data[s*DATA_W +: DATA_W]};
      end
    end
  end

  // Egress registers: strobe per grant, payload/source hold between grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_valid_q <= '0;
      for (int d = 0; d < int'(N_PORTS); d++) begin
        rx_data_q[d] <= '0;
        rx_src_q[d]  <= '0;
      end
    end else begin
      rx_valid_q <= gnt_vld_c;
      for (int d = 0; d < int'(N_PORTS); d++) begin
        if (gnt_vld_c[d]) begin
          rx_data_q[d] <= head_c[gnt_src_c[d]].data;
          rx_src_q[d]  <= DEST_W'(gnt_src_c[d]);
        end
      end
    end
  end

  // Flatten per-port registers onto the output buses.
  assign rx_valid = rx_valid_q;
  for (genvar p = 0; p < int'(N_PORTS); p++) begin : g_flat
    assign rx_data[p*DATA_W +: DATA_W]     = rx_data_q[p];
    assign rx_src[p*DEST_W +: DEST_W]      = rx_src_q[p];
    assign ovf_drop_cnt[p*CNT_W +: CNT_W]  = ovf_q[p];
    assign bad_dest_cnt[p*CNT_W +: CNT_W]  = bad_q[p];
  end

endmodule

// File: doc/tor_fanin_switch.md
Name: tor_fanin_switch

Overview:
- Buffered L3 switch that replaces the unbuffered loopback ToR used in multi-NIC loopback top levels.
- Sits between every NIC's network_tx_out and every NIC's network_rx_in, in the network clock domain.
- Each source port has its own ingress FIFO. A round-robin arbiter per destination port serialises fan-in traffic (N-to-1) so that simultaneous packets to the same destination are delivered rather than overwritten.
- Packets are dropped only on ingress FIFO overflow or an invalid destination, and every drop is counted.

Parameters:
- N_PORTS, 4, number of NIC ports (2..8).
- DATA_W, 512, width of a flattened network packet.
- DEST_W, 8, width of the destination field (dest_ip.b0).
- FIFO_DEPTH, 8, entries per ingress FIFO (power of 2, ≥2).
- CNT_W, 16, width of the drop counters.

Ports:
- clk, input, 1, network clock (clk_div_2 at the top level).
- reset, input, 1, synchronous, active-low: 0 = reset.
- tx_valid, input, N_PORTS, per-source packet strobe (one packet per cycle per source; no backpressure).
- tx_data, input, N_PORTS*DATA_W, per-source packet; source i occupies bits [i*DATA_W +: DATA_W].
- tx_dest, input, N_PORTS*DEST_W, per-source destination port index, sampled with tx_valid.
- rx_valid, output, N_PORTS, per-destination packet strobe (registered).
- rx_data, output, N_PORTS*DATA_W, per-destination packet (registered).
- rx_src, output, N_PORTS*DEST_W, source index of the delivered packet (registered).
- ovf_drop_cnt, output, N_PORTS*CNT_W, per-source count of packets dropped because the FIFO was full.
- bad_dest_cnt, output, N_PORTS*CNT_W, per-source count of packets dropped because tx_dest ≥ N_PORTS.

Behaviour:
- **Reset (reset==0 at posedge):**
  - All FIFOs empty.
  - rx_valid=0; rx_data and rx_src = 0.
  - All RR pointers = 0.
  - All counters = 0.
  - Reset overrides any push or pop in the same cycle. A mid-operation reset discards buffered packets, and no rx_valid is produced for them afterwards.
- **Ingress:**
  - Each cycle, for source i with tx_valid[i]=1:
    - If tx_dest[i] ≥ N_PORTS: drop, and bad_dest_cnt[i]++.
    - Else if FIFO i is full and not popped this cycle: drop, and ovf_drop_cnt[i]++.
    - Else: push {tx_dest, tx_data}.
  - A full FIFO that is popped in the same cycle accepts the push (occupancy unchanged).
  - Counters saturate at 2^CNT_W-1; they never wrap.
- **Arbitration (per destination d, every cycle):**
  - Requesters are the sources whose FIFO is non-empty and whose head entry has dest==d.
  - Grant the first requester at or after rr_ptr[d], searching upward modulo N_PORTS.
  - On a grant to source s, set rr_ptr[d]=(s+1) mod N_PORTS. With no requesters, rr_ptr[d] holds.
  - A source head targets exactly one destination, so each FIFO pops at most once per cycle. Grants to different destinations proceed in parallel.
  - Head-of-line blocking within one source is accepted.
- **Egress:**
  - rx_valid[d] is 1 for exactly one cycle per granted packet.
  - rx_data[d] is the head data; rx_src[d] is the granted source index s.
  - When there is no grant, rx_valid[d]=0 and rx_data[d]/rx_src[d] hold their previous values.
- **Latency:** a packet sampled at edge k into an empty FIFO with an idle destination appears with rx_valid=1 after edge k+1 (2-cycle tx_valid→rx_valid). There is no bypass path.
- **Throughput:** 1 packet/cycle per destination. Per-source packet order is preserved.
- **Self-loop:** tx_dest[i]==i is legal and delivered to port i.
- **Pointers:**
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits; full and empty are derived from the MSB comparison.
  - Wrap-around is exercised at every depth boundary.

Test Plan:
- **Single packet:** src0 sends data=0xA5 with dest=2 at cycle 10 → rx_valid[2]=1 exactly at cycle 12, rx_data=0xA5, rx_src=0. All other rx_valid stay 0 and all counters stay 0.
- **3-to-1 fan-in:** src1, src2 and src3 each send one packet to dest 0 in the same cycle (rr_ptr[0]=0) → port 0 receives them on 3 consecutive cycles in order src1, src2, src3. Zero drops.
- **RR fairness:** src1 and src2 stream to dest 0 continuously for 20 cycles → deliveries alternate 1,2,1,2…, and each source gets ≥ 8 deliveries. ovf_drop_cnt[1] and [2] then reflect the excess over the FIFO_DEPTH=8 buffering exactly: sent − delivered − remaining occupancy.
- **Overflow and simultaneous push/pop:**
  - src0, src1 and src2 each send 10 back-to-back packets to dest 3 (1 drain/cycle); the 3:1 oversubscription fills each FIFO.
  - Per-source delivered + ovf_drop_cnt = 10, with ordering preserved.
  - A push on a full FIFO during a pop cycle is not counted as a drop.
- **Invalid destination:** src2 sends dest=7 with N_PORTS=4 → no rx_valid on any port, and bad_dest_cnt[2]=1.
- **Reset mid-operation:** with 5 packets buffered, hold reset=0 for 1 cycle → no rx_valid for those packets. A new packet sent 1 cycle after reset release arrives with the 2-cycle latency, and all counters read 0 before it.
